bcd_to_7segment: RTL and testbench

Registered BCD-to-seven-segment decoder for a single display digit. It converts a 4-bit BCD digit to segment drive `a`..`g` with one clock of latency. It also provides lamp test, blanking, ripple blanking for multi-digit leading-zero suppression, and an invalid-code flag. It sits between the digit-select/BCD datapath and the display pin drivers.

---
 rtl/bcd_to_7segment.sv | 75 +++++++
 tb/tb_bcd_to_7segment.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/bcd_to_7segment.sv
// Registered BCD-to-seven-segment decoder for one display digit.
// It supports lamp test, blanking, ripple blanking and an invalid-code flag.
module bcd_to_7segment #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd,
    input  logic       lamp_test,
    input  logic       blank,
    input  logic       rbi,
    output logic [6:0] seg,
    output logic       rbo,
    output logic       err
);

    localparam logic [6:0] SEG_OFF = 7'b0000000;
    localparam logic [6:0] SEG_ALL = 7'b1111111;
    localparam logic [6:0] POLARITY = {7{ACTIVE_LOW}};

    logic [6:0] glyph;
    logic       invalid;
    logic       suppress;
    logic [6:0] seg_logical;
    logic       rbo_next;

    // Segment order is {a,b,c,d,e,f,g}, and 1 means lit.
    always_comb begin
        glyph = SEG_OFF;
        unique case (bcd)
            4'd0:    glyph = 7'b1111110;
            4'd1:    glyph = 7'b0110000;
            4'd2:    glyph = 7'b1101101;
            4'd3:    glyph = 7'b1111001;
            4'd4:    glyph = 7'b0110011;
            4'd5:    glyph = 7'b1011011;
            4'd6:    glyph = 7'b1011111;
            4'd7:    glyph = 7'b1110000;
            4'd8:    glyph = 7'b1111111;
            4'd9:    glyph = 7'b1111011;
            default: glyph = SEG_OFF;
        endcase
    end

    assign invalid  = (bcd > 4'd9);
    assign suppress = rbi && (bcd == 4'd0);

    // Lamp test beats blank, and blank beats ripple suppression.
    always_comb begin
        seg_logical = glyph;
        rbo_next    = 1'b0;
        if (lamp_test) begin
            seg_logical = SEG_ALL;
        end else if (blank) begin
            seg_logical = SEG_OFF;
        end else if (suppress) begin
            seg_logical = SEG_OFF;
            rbo_next    = 1'b1;
        end
    end

    // A suppressed digit is always 0, so the err flag ignores the overrides.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_OFF ^ POLARITY;
            rbo <= 1'b0;
            err <= 1'b0;
        end else begin
            seg <= seg_logical ^ POLARITY;
            rbo <= rbo_next;
            err <= invalid;
        end
    end

endmodule

// File: tb/tb_bcd_to_7segment.sv
// Self-checking bench for bcd_to_7segment, with one active-high and one active-low instance.
// It uses directed vectors, then random stimulus checked against a reference model.
module tb_bcd_to_7segment;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] bcd;
    logic       lamp_test;
    logic       blank;
    logic       rbi;
    logic [6:0] seg_h;
    logic       rbo_h;
    logic       err_h;
    logic [6:0] seg_l;
    logic       rbo_l;
    logic       err_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_to_7segment #(.ACTIVE_LOW(1'b0)) dut_h (
        .clk(clk), .rst(rst), .bcd(bcd), .lamp_test(lamp_test), .blank(blank),
        .rbi(rbi), .seg(seg_h), .rbo(rbo_h), .err(err_h)
    );

    bcd_to_7segment #(.ACTIVE_LOW(1'b1)) dut_l (
        .clk(clk), .rst(rst), .bcd(bcd), .lamp_test(lamp_test), .blank(blank),
        .rbi(rbi), .seg(seg_l), .rbo(rbo_l), .err(err_l)
    );

    typedef struct {
        logic       rst;
        logic [3:0] bcd;
        logic       lamp_test;
        logic       blank;
        logic       rbi;
        logic [6:0] exp_seg;
        logic       exp_rbo;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    // Digit shapes written as the set of lit segments, a..g.
    logic [6:0] shapes [10];
    initial begin
        shapes[0] = 7'b1111110; shapes[1] = 7'b0110000; shapes[2] = 7'b1101101;
        shapes[3] = 7'b1111001; shapes[4] = 7'b0110011; shapes[5] = 7'b1011011;
        shapes[6] = 7'b1011111; shapes[7] = 7'b1110000; shapes[8] = 7'b1111111;
        shapes[9] = 7'b1111011;
    end

    function automatic vec_t model(input logic r, input logic [3:0] b,
                                   input logic lt, input logic bl, input logic ri);
        vec_t v;
        v.rst = r; v.bcd = b; v.lamp_test = lt; v.blank = bl; v.rbi = ri;
        v.exp_err = !r && (int'(b) >= 10);
        v.exp_rbo = 1'b0;
        if (r)                    v.exp_seg = 7'd0;
        else if (lt)              v.exp_seg = 7'h7f;
        else if (bl)              v.exp_seg = 7'd0;
        else if (ri && b == 4'd0) begin v.exp_seg = 7'd0; v.exp_rbo = 1'b1; end
        else if (int'(b) >= 10)   v.exp_seg = 7'd0;
        else                      v.exp_seg = shapes[int'(b)];
        return v;
    endfunction

    function automatic vec_t mk(input logic r, input logic [3:0] b, input logic lt,
                                input logic bl, input logic ri, input logic [6:0] s,
                                input logic o, input logic e);
        vec_t v;
        v.rst = r; v.bcd = b; v.lamp_test = lt; v.blank = bl; v.rbi = ri;
        v.exp_seg = s; v.exp_rbo = o; v.exp_err = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        rst = v.rst; bcd = v.bcd; lamp_test = v.lamp_test; blank = v.blank; rbi = v.rbi;
        @(posedge clk);
        #1;
        check({tag, " seg"},   seg_h, v.exp_seg);
        check({tag, " rbo"},   {6'd0, rbo_h}, {6'd0, v.exp_rbo});
        check({tag, " err"},   {6'd0, err_h}, {6'd0, v.exp_err});
        check({tag, " seg_n"}, seg_l, v.exp_seg ^ 7'h7f);
        check({tag, " rbo_n"}, {6'd0, rbo_l}, {6'd0, v.exp_rbo});
        check({tag, " err_n"}, {6'd0, err_l}, {6'd0, v.exp_err});
    endtask

    initial begin
        rst = 1'b1; bcd = 4'd8; lamp_test = 1'b0; blank = 1'b0; rbi = 1'b0;

        // Reset hold with 8 on the input, then release.
        vecs.push_back(mk(1, 4'd8, 0, 0, 0, 7'b0000000, 0, 0));
        vecs.push_back(mk(1, 4'd8, 0, 0, 0, 7'b0000000, 0, 0));
        vecs.push_back(mk(0, 4'd8, 0, 0, 0, 7'b1111111, 0, 0));
        // Sweep of the valid digits.
        vecs.push_back(mk(0, 4'd0, 0, 0, 0, 7'b1111110, 0, 0));
        vecs.push_back(mk(0, 4'd1, 0, 0, 0, 7'b0110000, 0, 0));
        vecs.push_back(mk(0, 4'd2, 0, 0, 0, 7'b1101101, 0, 0));
        vecs.push_back(mk(0, 4'd3, 0, 0, 0, 7'b1111001, 0, 0));
        vecs.push_back(mk(0, 4'd4, 0, 0, 0, 7'b0110011, 0, 0));
        vecs.push_back(mk(0, 4'd5, 0, 0, 0, 7'b1011011, 0, 0));
        vecs.push_back(mk(0, 4'd6, 0, 0, 0, 7'b1011111, 0, 0));
        vecs.push_back(mk(0, 4'd7, 0, 0, 0, 7'b1110000, 0, 0));
        vecs.push_back(mk(0, 4'd8, 0, 0, 0, 7'b1111111, 0, 0));
        vecs.push_back(mk(0, 4'd9, 0, 0, 0, 7'b1111011, 0, 0));
        // Invalid codes, then back to a valid one.
        for (int c = 10; c < 16; c++)
            vecs.push_back(mk(0, 4'(c), 0, 0, 0, 7'b0000000, 0, 1));
        vecs.push_back(mk(0, 4'd3, 0, 0, 0, 7'b1111001, 0, 0));
        // Overrides on an invalid code.
        vecs.push_back(mk(0, 4'd10, 1, 0, 0, 7'b1111111, 0, 1));
        vecs.push_back(mk(0, 4'd10, 1, 1, 0, 7'b1111111, 0, 1));
        vecs.push_back(mk(0, 4'd10, 0, 1, 0, 7'b0000000, 0, 1));
        // Ripple blanking.
        vecs.push_back(mk(0, 4'd0, 0, 0, 1, 7'b0000000, 1, 0));
        vecs.push_back(mk(0, 4'd5, 0, 0, 1, 7'b1011011, 0, 0));
        vecs.push_back(mk(0, 4'd0, 0, 0, 0, 7'b1111110, 0, 0));
        vecs.push_back(mk(0, 4'd0, 0, 1, 1, 7'b0000000, 0, 0));
        vecs.push_back(mk(0, 4'd0, 1, 0, 1, 7'b1111111, 0, 0));
        vecs.push_back(mk(0, 4'd0, 0, 0, 1, 7'b0000000, 1, 0));
        // Reset mid-stream, then the first decode after release.
        vecs.push_back(mk(1, 4'd12, 1, 0, 0, 7'b0000000, 0, 0));
        vecs.push_back(mk(0, 4'd1, 0, 0, 0, 7'b0110000, 0, 0));

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 400; i++) begin
            vec_t v;
            v = model($urandom_range(0, 19) == 0, 4'($urandom_range(0, 15)),
                      $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                      1'($urandom_range(0, 1)));
            apply(v, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
